// File: rtl/mp_reg_file_pkg.sv
// Shared constants for the multi-port register file.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH / DEF_NUM_RD : default parameter values
//   NUM_WR         : fixed number of write ports
//   WR_COUNT_WIDTH : width of the committed-write counter
package mp_reg_file_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NUM_RD     = 2;
    localparam int NUM_WR         = 2;
    localparam int WR_COUNT_WIDTH = 16;
endpackage

// File: rtl/mp_reg_file_if.sv
// Bus bundle for mp_reg_file.
//   wen/waddr/wdata : two write ports, port p in slice p of each vector
//   raddr/rdata     : NUM_RD read ports, port r in slice r
//   wr_conflict     : one-cycle pulse after a same-address dual write
//   wr_count        : wrapping count of committed writes
// The parameters must match those of the mp_reg_file instance it connects to.
interface mp_reg_file_if
    import mp_reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_RD     = DEF_NUM_RD
);
    logic [NUM_WR-1:0]            wen;
    logic [NUM_WR*ADDR_WIDTH-1:0] waddr;
    logic [NUM_WR*DATA_WIDTH-1:0] wdata;
    logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
    logic [NUM_RD*DATA_WIDTH-1:0] rdata;
    logic                         wr_conflict;
    logic [WR_COUNT_WIDTH-1:0]    wr_count;

    modport master (
        output wen, waddr, wdata, raddr,
        input  rdata, wr_conflict, wr_count
    );

    modport slave (
        input  wen, waddr, wdata, raddr,
        output rdata, wr_conflict, wr_count
    );
endinterface

// File: rtl/rf_rd_port.sv
// One combinational read port of the register file.
//   rst   : forces the output to zero while reset is held
//   raddr : read address
//   regs  : full stored array (pre-edge contents)
//   wen/waddr/wdata : current write-port activity, used for forwarding
//   rdata : read result
module rf_rd_port
    import mp_reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BYPASS     = 1
) (
    input  logic                                         rst,
    input  logic [ADDR_WIDTH-1:0]                        raddr,
    input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0]     regs,
    input  logic [NUM_WR-1:0]                            wen,
    input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]            waddr,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]            wdata,
    output logic [DATA_WIDTH-1:0]                        rdata
);
    always_comb begin
        rdata = regs[raddr];
        if (BYPASS != 0) begin
            // Ascending scan: the higher-numbered write port overrides,
            // matching the port-1-wins commit priority.
            for (int p = 0; p < NUM_WR; p++) begin
                if (wen[p] && (waddr[p] == raddr)) begin
                    rdata = wdata[p];
                end
            end
        end
        // Zero register and reset override any forwarded data.
        if (rst || (raddr == '0)) begin
            rdata = '0;
        end
    end
endmodule

// File: rtl/mp_reg_file.sv
// Multi-port register file: two write ports, NUM_RD combinational read ports,
// hard-wired zero register, optional write-to-read forwarding.
//   clk : clock, rst : asynchronous active-high reset
//   bus : mp_reg_file_if slave (write ports, read ports, status outputs)
module mp_reg_file
    import mp_reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int BYPASS     = 1
) (
    input  logic          clk,
    input  logic          rst,
    mp_reg_file_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0]   regs_reg;
    logic [NUM_WR-1:0][ADDR_WIDTH-1:0]  waddr_p;
    logic [NUM_WR-1:0][DATA_WIDTH-1:0]  wdata_p;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0]  raddr_p;
    logic [DATA_WIDTH-1:0]              rdata_p [NUM_RD];
    logic [NUM_WR-1:0]                  commit;
    logic                               conflict_next;
    logic                               conflict_reg;
    logic [WR_COUNT_WIDTH-1:0]          count_next;
    logic [WR_COUNT_WIDTH-1:0]          count_reg;

    // Packed views line up with the flat bus slices (port p at index p).
    assign waddr_p = bus.waddr;
    assign wdata_p = bus.wdata;
    assign raddr_p = bus.raddr;

    // Port 0 loses to port 1 on a shared address, so its write is dropped
    // entirely and counted as no commit.
    always_comb begin
        commit[1]     = bus.wen[1] && (waddr_p[1] != '0);
        commit[0]     = bus.wen[0] && (waddr_p[0] != '0) &&
                        !(commit[1] && (waddr_p[0] == waddr_p[1]));
        conflict_next = bus.wen[0] && bus.wen[1] &&
                        (waddr_p[0] == waddr_p[1]) && (waddr_p[0] != '0);
        count_next    = count_reg + WR_COUNT_WIDTH'(commit[0])
                                  + WR_COUNT_WIDTH'(commit[1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_reg     <= '0;
            conflict_reg <= 1'b0;
            count_reg    <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (commit[p]) begin
                    regs_reg[waddr_p[p]] <= wdata_p[p];
                end
            end
            conflict_reg <= conflict_next;
            count_reg    <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            rf_rd_port #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .BYPASS     (BYPASS)
            ) u_rd_port (
                .rst   (rst),
                .raddr (raddr_p[gi]),
                .regs  (regs_reg),
                .wen   (bus.wen),
                .waddr (waddr_p),
                .wdata (wdata_p),
                .rdata (rdata_p[gi])
            );
        end
    endgenerate

    always_comb begin
        bus.rdata = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            bus.rdata[r*DATA_WIDTH +: DATA_WIDTH] = rdata_p[r];
        end
    end

    assign bus.wr_conflict = conflict_reg;
    assign bus.wr_count    = count_reg;
endmodule
